// File: rtl/key_sched_pkg.sv
// Shared keycode constants, dispatch state encoding and routing helper
// for the key event scheduler.
package key_sched_pkg;

  localparam logic [7:0] KC_NULL  = 8'h00;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_ESC   = 8'h76;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BREAK = 8'hF0;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } sched_state_e;

  // Run-control keys; everything else belongs to the tape editor.
  function automatic logic is_run_key(input logic [7:0] code);
    return (code == KC_ENTER) || (code == KC_ESC) || (code == KC_SPACE);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small keycode FIFO. Occupancy is tracked in its own counter so full and
// empty never alias; the caller only pushes or pops when that is legal.
module key_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Filters keyboard events, buffers them and dispatches them in order to the
// tape editor or run controller over a registered valid/ready interface.
module key_event_scheduler
  import key_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int REPEAT_HOLD = 4000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [7:0]               keycode,
  output logic                     ed_valid,
  output logic [7:0]               ed_code,
  input  logic                     ed_ready,
  output logic                     rc_valid,
  output logic [7:0]               rc_code,
  input  logic                     rc_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(REPEAT_HOLD + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [RW-1:0] HOLD_C  = RW'(REPEAT_HOLD);

  // Valid/ready: a valid stays high with a stable code until its own ready
  // is seen high on a rising edge; the transfer happens on that edge.
  // A ready without its matching valid has no effect.

  sched_state_e  state_q, state_d;
  logic          ed_valid_q, ed_valid_d, rc_valid_q, rc_valid_d;
  logic [7:0]    ed_code_q, ed_code_d, rc_code_q, rc_code_d;
  logic [7:0]    last_q, last_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          overflow_q, overflow_d;

  logic          key_ok, xfer, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (keycode),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_comb begin
    key_ok = key_valid && (keycode != KC_NULL) && (keycode != KC_EXT) &&
             (keycode != KC_BREAK) && !((keycode == last_q) && (rpt_q != '0));
    xfer      = (ed_valid_q && ed_ready) || (rc_valid_q && rc_ready);
    fifo_pop  = (fifo_count != '0) && ((state_q == ST_IDLE) || xfer);
    // A full FIFO still takes the event when the head leaves this cycle.
    fifo_push = key_ok && ((fifo_count < DEPTH_C) || fifo_pop);

    overflow_d = overflow_q | (key_ok & ~fifo_push);
    last_d     = fifo_push ? keycode : last_q;
    if (fifo_push)         rpt_d = HOLD_C;
    else if (rpt_q != '0)  rpt_d = rpt_q - RW'(1);
    else                   rpt_d = rpt_q;

    state_d    = state_q;
    ed_valid_d = ed_valid_q;
    rc_valid_d = rc_valid_q;
    ed_code_d  = ed_code_q;
    rc_code_d  = rc_code_q;
    if (fifo_pop) begin
      state_d = ST_OFFER;
      if (is_run_key(fifo_dout)) begin
        rc_valid_d = 1'b1;
        rc_code_d  = fifo_dout;
        ed_valid_d = 1'b0;
        ed_code_d  = KC_NULL;
      end else begin
        ed_valid_d = 1'b1;
        ed_code_d  = fifo_dout;
        rc_valid_d = 1'b0;
        rc_code_d  = KC_NULL;
      end
    end else if ((state_q == ST_OFFER) && xfer) begin
      state_d    = ST_IDLE;
      ed_valid_d = 1'b0;
      rc_valid_d = 1'b0;
      ed_code_d  = KC_NULL;
      rc_code_d  = KC_NULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ed_valid_q <= 1'b0;
      rc_valid_q <= 1'b0;
      ed_code_q  <= KC_NULL;
      rc_code_q  <= KC_NULL;
      last_q     <= KC_NULL;
      rpt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ed_valid_q <= ed_valid_d;
      rc_valid_q <= rc_valid_d;
      ed_code_q  <= ed_code_d;
      rc_code_q  <= rc_code_d;
      last_q     <= last_d;
      rpt_q      <= rpt_d;
      overflow_q <= overflow_d;
    end
  end

  assign ed_valid = ed_valid_q;
  assign ed_code  = ed_code_q;
  assign rc_valid = rc_valid_q;
  assign rc_code  = rc_code_q;
  assign overflow = overflow_q;
  assign count    = fifo_count;

endmodule
